// File: rtl/regfile_opfetch.sv
// Operand fetch: 8x8 register file (2R/1W, write-through bypass), op2 imm mux, one registered output stage.
// Latency 1 cycle, full throughput; in_ready = !out_valid || out_ready. Define REG0_ZERO_EN to hardwire register 0 to zero.
module regfile_opfetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic [2:0]        sel_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [2:0]        alu_sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

`ifdef REG0_ZERO_EN
  localparam int RF_LO = 1;
`else
  localparam int RF_LO = 0;
`endif

  logic [DATA_W-1:0] rf_q [RF_LO:NREG-1];
  logic              wr_eff;
  logic              accept;
  logic [DATA_W-1:0] op1_nxt;
  logic [DATA_W-1:0] op2_nxt;

  always_comb begin
`ifdef REG0_ZERO_EN
    wr_eff = wr_en && (wr_addr != '0);
`else
    wr_eff = wr_en;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = RF_LO; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_eff) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  // Same-cycle write is forwarded so an instruction issued alongside its producer's writeback sees the new value.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
`ifdef REG0_ZERO_EN
    if (a == '0) begin
      v = '0;
    end else
`endif
    if (wr_eff && (wr_addr == a)) begin
      v = wr_data;
    end else begin
      v = rf_q[a];
    end
    return v;
  endfunction

  always_comb begin
    op1_nxt = rd_port(rs1_addr);
    op2_nxt = imm_sel ? imm : rd_port(rs2_addr);
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output operands are a snapshot: later register writes do not disturb a held set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      alu_sel   <= 3'b000;
    end else if (accept) begin
      out_valid <= 1'b1;
      op1       <= op1_nxt;
      op2       <= op2_nxt;
      alu_sel   <= sel_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_opfetch.sv
// Scoreboard bench for regfile_opfetch: stimulus pushes hand-computed operand sets, a forked monitor pops on each transfer.
module tb_regfile_opfetch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, imm_sel, out_valid, out_ready, wr_en;
  logic [2:0] rs1_addr, rs2_addr, sel_in, alu_sel, wr_addr;
  logic [7:0] imm, op1, op2, wr_data;

  int checks = 0;
  int errors = 0;
  logic [18:0] sb_q [$];

`ifdef REG0_ZERO_EN
  localparam logic [7:0] R0_EXP = 8'h00;
`else
  localparam logic [7:0] R0_EXP = 8'h55;
`endif

  regfile_opfetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm), .imm_sel(imm_sel), .sel_in(sel_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .alu_sel(alu_sel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got op1=%0h op2=%0h sel=%0h expected none", op1, op2, alu_sel);
        end else begin
          e = sb_q.pop_front();
          chk("xfer_op1", {24'h0, op1}, {24'h0, e[18:11]});
          chk("xfer_op2", {24'h0, op2}, {24'h0, e[10:3]});
          chk("xfer_sel", {29'h0, alu_sel}, {29'h0, e[2:0]});
        end
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Presents one operand set and holds it until accepted; leaves in_valid high for back-to-back use.
  task automatic issue(input logic [2:0] r1, input logic [2:0] r2, input logic [7:0] im, input logic is,
                       input logic [2:0] s, input logic [7:0] e1, input logic [7:0] e2, input bit push);
    int n;
    rs1_addr = r1; rs2_addr = r2; imm = im; imm_sel = is; sel_in = s; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else if (push) begin
      sb_q.push_back({e1, e2, s});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] stream_op1 [8];

  initial begin
    stream_op1 = '{8'h00, 8'hFF, 8'h7F, 8'h2A, 8'h00, 8'h15, 8'h00, 8'h00};
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wr_en = 1'b0;
    rs1_addr = '0; rs2_addr = '0; imm = '0; imm_sel = 1'b0; sel_in = '0; wr_addr = '0; wr_data = '0;
    fork
      monitor();
    join_none
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_op1", {24'h0, op1}, 32'h0);
    chk("rst_op2", {24'h0, op2}, 32'h0);
    chk("rst_sel", {29'h0, alu_sel}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) issue(3'(i), 3'(i), 8'h00, 1'b0, 3'(i), 8'h00, 8'h00, 1'b1);
    idle(1);

    // Plain register read
    wr(3'd3, 8'h2A);
    wr(3'd5, 8'h15);
    issue(3'd3, 3'd5, 8'h00, 1'b0, 3'b001, 8'h2A, 8'h15, 1'b1);
    chk("seq_out_valid", {31'h0, out_valid}, 32'h1);
    idle(1);

    // Same-cycle write bypass
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h7F;
    issue(3'd2, 3'd0, 8'h03, 1'b1, 3'b010, 8'h7F, 8'h03, 1'b1);
    wr_en = 1'b0;
    issue(3'd2, 3'd2, 8'h00, 1'b0, 3'b011, 8'h7F, 8'h7F, 1'b1);
    idle(1);

    // Backpressure with a later write to the held op1 source
    wr(3'd1, 8'h11);
    out_ready = 1'b0;
    issue(3'd1, 3'd3, 8'h00, 1'b0, 3'b100, 8'h11, 8'h2A, 1'b1);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_op1_hold", {24'h0, op1}, 32'h11);
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    out_ready = 1'b1;
    issue(3'd1, 3'd5, 8'h00, 1'b0, 3'b101, 8'hFF, 8'h15, 1'b1);
    chk("bp_reload_valid", {31'h0, out_valid}, 32'h1);
    idle(1);

    // Streaming: one accept per cycle, no bubbles
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 3'd0, 8'h80 + 8'(i), 1'b1, 3'(i), stream_op1[i], 8'h80 + 8'(i), 1'b1);
      chk("stream_valid", {31'h0, out_valid}, 32'h1);
    end
    idle(2);

    // Register 0 write with simultaneous read
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
    issue(3'd0, 3'd0, 8'h00, 1'b1, 3'b100, R0_EXP, 8'h00, 1'b1);
    wr_en = 1'b0;
    issue(3'd0, 3'd0, 8'h00, 1'b0, 3'b101, R0_EXP, R0_EXP, 1'b1);
    idle(2);

    // Asynchronous reset while a set is stalled; a write during reset must not land
    out_ready = 1'b0;
    issue(3'd3, 3'd5, 8'h00, 1'b0, 3'b110, 8'h2A, 8'h15, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_op1", {24'h0, op1}, 32'h0);
    chk("mid_rst_op2", {24'h0, op2}, 32'h0);
    chk("mid_rst_sel", {29'h0, alu_sel}, 32'h0);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h99;
    @(posedge clk); #1;
    wr_en = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(3'(i), 3'(7 - i), 8'h00, 1'b0, 3'(i), 8'h00, 8'h00, 1'b1);
    idle(3);

    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish before 50000");
    $fatal(1, "timeout");
  end
endmodule
